// File: rtl/rf_wb_arbiter_pkg.sv
// Core-wide register file constants and the writeback request record
// shared by the writeback arbiter and its clients.
package rf_wb_arbiter_pkg;

    localparam int REGISTER_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // x0 is hardwired to zero; writes to it are accepted and discarded
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG_ADDR = '0;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [REGISTER_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin priority pick: first asserted request at or after the pointer,
// with wrap-around; returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    logic [PTR_W:0] cand;

    // Walk from the farthest candidate back to the pointer so the closest
    // requester is the last one written and therefore wins.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N)) begin
                cand = cand - (PTR_W+1)'(N);
            end
            if (req_i[cand[PTR_W-1:0]]) begin
                grant_idx_o   = cand[PTR_W-1:0];
                grant_valid_o = 1'b1;
            end
        end
        if (grant_valid_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter feeding the register file write port through
// a one-entry commit stage. Optional operand forwarding: RF_WB_BYPASS_EN.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int REGISTER_WIDTH = rf_wb_arbiter_pkg::REGISTER_WIDTH,
    parameter int REG_ADDR_WIDTH = rf_wb_arbiter_pkg::REG_ADDR_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*REGISTER_WIDTH-1:0]   req_data,
    output logic                                rf_we,
    output logic [REG_ADDR_WIDTH-1:0]           rf_rd_addr,
    output logic [REGISTER_WIDTH-1:0]           rf_rd_data,
    output logic                                busy
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [REG_ADDR_WIDTH-1:0]           byp_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]           byp_rs2_addr,
    output logic                                byp_rs1_hit,
    output logic                                byp_rs2_hit,
    output logic [REGISTER_WIDTH-1:0]           byp_rs1_data,
    output logic [REGISTER_WIDTH-1:0]           byp_rs2_data
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                      stg_valid_q, stg_valid_d;
    logic [REG_ADDR_WIDTH-1:0] stg_addr_q, stg_addr_d;
    logic [REGISTER_WIDTH-1:0] stg_data_q, stg_data_d;
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;

    logic                      stg_free;
    logic [NUM_REQ-1:0]        grant;
    logic [PTR_W-1:0]          grant_idx;
    logic                      grant_valid;
    logic [REG_ADDR_WIDTH-1:0] sel_addr;
    logic [REGISTER_WIDTH-1:0] sel_data;

    // The stage can take a new entry when empty or when it drains this cycle
    assign stg_free = !stg_valid_q || start;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i         (req_valid & {NUM_REQ{stg_free}}),
        .ptr_i         (rr_ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign req_ready = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                sel_data = req_data[i*REGISTER_WIDTH +: REGISTER_WIDTH];
            end
        end
    end

    always_comb begin
        stg_valid_d = stg_valid_q && !start;
        stg_addr_d  = stg_addr_q;
        stg_data_d  = stg_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            // Writes to x0 are consumed here and never reach the register file
            if (sel_addr != REG_ADDR_WIDTH'(ZERO_REG_ADDR)) begin
                stg_valid_d = 1'b1;
                stg_addr_d  = sel_addr;
                stg_data_d  = sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_addr_q  <= '0;
            stg_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_addr_q  <= stg_addr_d;
            stg_data_q  <= stg_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rf_we      = stg_valid_q && start;
    assign rf_rd_addr = stg_addr_q;
    assign rf_rd_data = stg_data_q;
    assign busy       = stg_valid_q;

`ifdef RF_WB_BYPASS_EN
    // Forward the pending write to readers of the same non-zero register
    assign byp_rs1_hit  = stg_valid_q && (stg_addr_q == byp_rs1_addr)
                          && (byp_rs1_addr != REG_ADDR_WIDTH'(ZERO_REG_ADDR));
    assign byp_rs2_hit  = stg_valid_q && (stg_addr_q == byp_rs2_addr)
                          && (byp_rs2_addr != REG_ADDR_WIDTH'(ZERO_REG_ADDR));
    assign byp_rs1_data = stg_data_q;
    assign byp_rs2_data = stg_data_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: handshake, round-robin order, start gating,
// x0 drop and asynchronous reset, plus forwarding when RF_WB_BYPASS_EN is set.
module tb_rf_wb_arbiter;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [NR-1:0]    reqValid;
    logic [NR-1:0]    reqReady;
    logic [NR*AW-1:0] reqAddr;
    logic [NR*DW-1:0] reqData;
    logic             rfWe;
    logic [AW-1:0]    rfRdAddr;
    logic [DW-1:0]    rfRdData;
    logic             busy;
`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0]    bypRs1Addr;
    logic [AW-1:0]    bypRs2Addr;
    logic             bypRs1Hit;
    logic             bypRs2Hit;
    logic [DW-1:0]    bypRs1Data;
    logic [DW-1:0]    bypRs2Data;
`endif

    int passCount = 0;
    int checkCount = 0;

    rf_wb_arbiter #(
        .NUM_REQ        (NR),
        .REGISTER_WIDTH (DW),
        .REG_ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_addr   (reqAddr),
        .req_data   (reqData),
        .rf_we      (rfWe),
        .rf_rd_addr (rfRdAddr),
        .rf_rd_data (rfRdData),
        .busy       (busy)
`ifdef RF_WB_BYPASS_EN
        ,
        .byp_rs1_addr (bypRs1Addr),
        .byp_rs2_addr (bypRs2Addr),
        .byp_rs1_hit  (bypRs1Hit),
        .byp_rs2_hit  (bypRs2Hit),
        .byp_rs1_data (bypRs1Data),
        .byp_rs2_data (bypRs2Data)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Drives start/valid just after an edge and lets the comb logic settle
    task automatic applyStimulus(input logic startVal, input logic [NR-1:0] validVal);
        start    = startVal;
        reqValid = validVal;
        #1;
    endtask

    task automatic setReq(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        reqAddr[idx*AW +: AW] = a;
        reqData[idx*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        reqValid = '0;
        reqAddr  = '0;
        reqData  = '0;
`ifdef RF_WB_BYPASS_EN
        bypRs1Addr = '0;
        bypRs2Addr = '0;
`endif
        #2;
        $display("[TB] reset values");
        checkOutput("rst_we",    32'(rfWe),     32'd0);
        checkOutput("rst_addr",  32'(rfRdAddr), 32'd0);
        checkOutput("rst_data",  rfRdData,      32'd0);
        checkOutput("rst_busy",  32'(busy),     32'd0);
        checkOutput("rst_ready", 32'(reqReady), 32'd0);
        tick();
        rst = 1'b0;
        #1;

        $display("[TB] single write, one-cycle latency");
        setReq(0, 5'd5, 32'hDEADBEEF);
        applyStimulus(1'b1, 3'b001);
        checkOutput("t1_ready0", 32'(reqReady), 32'b001);
        checkOutput("t1_we0",    32'(rfWe),     32'd0);
        tick();
        applyStimulus(1'b1, 3'b000);
        checkOutput("t1_we1",    32'(rfWe),     32'd1);
        checkOutput("t1_addr1",  32'(rfRdAddr), 32'd5);
        checkOutput("t1_data1",  rfRdData,      32'hDEADBEEF);
        checkOutput("t1_busy1",  32'(busy),     32'd1);
        checkOutput("t1_ready1", 32'(reqReady), 32'b000);
        tick();
        checkOutput("t1_busy2",  32'(busy),     32'd0);
        checkOutput("t1_we2",    32'(rfWe),     32'd0);

        $display("[TB] round-robin with all requesters valid");
        doReset();
        setReq(0, 5'd1, 32'h000000A0);
        setReq(1, 5'd2, 32'h000000A1);
        setReq(2, 5'd3, 32'h000000A2);
        applyStimulus(1'b1, 3'b111);
        for (int k = 0; k < 6; k++) begin
            checkOutput("rr_ready", 32'(reqReady), 32'(1 << (k % 3)));
            if (k > 0) begin
                checkOutput("rr_we",   32'(rfWe),     32'd1);
                checkOutput("rr_addr", 32'(rfRdAddr), 32'((k - 1) % 3 + 1));
                checkOutput("rr_data", rfRdData,      32'(32'hA0 + (k - 1) % 3));
            end
            tick();
        end
        applyStimulus(1'b1, 3'b000);
        checkOutput("rr_we_last",   32'(rfWe),     32'd1);
        checkOutput("rr_addr_last", 32'(rfRdAddr), 32'd3);
        tick();
        checkOutput("rr_busy_end",  32'(busy),     32'd0);

        $display("[TB] start low holds one accepted write");
        setReq(1, 5'd7, 32'h00000077);
        applyStimulus(1'b0, 3'b010);
        checkOutput("s0_ready", 32'(reqReady), 32'b010);
        tick();
        checkOutput("s0_busy",   32'(busy),     32'd1);
        checkOutput("s0_we",     32'(rfWe),     32'd0);
        checkOutput("s0_ready1", 32'(reqReady), 32'b000);
        checkOutput("s0_addr",   32'(rfRdAddr), 32'd7);
        tick();
        checkOutput("s0_hold_busy",  32'(busy),     32'd1);
        checkOutput("s0_hold_ready", 32'(reqReady), 32'b000);
        setReq(1, 5'd8, 32'h00000088);
        applyStimulus(1'b1, 3'b010);
        checkOutput("s1_we",    32'(rfWe),     32'd1);
        checkOutput("s1_addr",  32'(rfRdAddr), 32'd7);
        checkOutput("s1_data",  rfRdData,      32'h00000077);
        checkOutput("s1_ready", 32'(reqReady), 32'b010);
        tick();
        checkOutput("s1_refill_we",   32'(rfWe),     32'd1);
        checkOutput("s1_refill_addr", 32'(rfRdAddr), 32'd8);
        checkOutput("s1_refill_data", rfRdData,      32'h00000088);
        applyStimulus(1'b1, 3'b000);
        tick();
        checkOutput("s1_busy_end", 32'(busy), 32'd0);

        $display("[TB] write to x0 is accepted and dropped");
        setReq(2, 5'd0, 32'h00001234);
        applyStimulus(1'b1, 3'b100);
        checkOutput("x0_ready", 32'(reqReady), 32'b100);
        tick();
        applyStimulus(1'b1, 3'b000);
        checkOutput("x0_we",   32'(rfWe), 32'd0);
        checkOutput("x0_busy", 32'(busy), 32'd0);
        // pointer is now 0, so requester 1 beats requester 2
        applyStimulus(1'b1, 3'b110);
        checkOutput("x0_ptr_wrap", 32'(reqReady), 32'b010);
        applyStimulus(1'b1, 3'b000);

        $display("[TB] asynchronous reset discards staged write");
        setReq(0, 5'd31, 32'h0000CAFE);
        applyStimulus(1'b0, 3'b001);
        checkOutput("ar_ready", 32'(reqReady), 32'b001);
        tick();
        applyStimulus(1'b0, 3'b000);
        checkOutput("ar_busy_pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_busy",  32'(busy),     32'd0);
        checkOutput("ar_we",    32'(rfWe),     32'd0);
        checkOutput("ar_addr",  32'(rfRdAddr), 32'd0);
        checkOutput("ar_data",  rfRdData,      32'd0);
        checkOutput("ar_ready0", 32'(reqReady), 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 3'b000);
        checkOutput("ar_after_we",   32'(rfWe), 32'd0);
        tick();
        checkOutput("ar_after_we2",  32'(rfWe), 32'd0);
        checkOutput("ar_after_busy", 32'(busy), 32'd0);

`ifdef RF_WB_BYPASS_EN
        $display("[TB] forwarding from the commit stage");
        setReq(0, 5'd9, 32'h00000055);
        applyStimulus(1'b0, 3'b001);
        tick();
        applyStimulus(1'b0, 3'b000);
        bypRs1Addr = 5'd9;
        bypRs2Addr = 5'd0;
        #1;
        checkOutput("byp_rs1_hit",  32'(bypRs1Hit), 32'd1);
        checkOutput("byp_rs1_data", bypRs1Data,     32'h00000055);
        checkOutput("byp_rs2_hit",  32'(bypRs2Hit), 32'd0);
        bypRs2Addr = 5'd10;
        #1;
        checkOutput("byp_rs2_miss", 32'(bypRs2Hit), 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
